// File: rtl/wb_write_queue.sv
// -----------------------------------------------------------------------------
// wb_write_queue
//
// Writeback end of the decode-stage register-file write port. Results from
// execute/memory arrive over a valid/ready handshake. Register-writing opcodes
// with a legal destination are buffered in an in-order queue. One write per
// cycle is retired to the register file through registered wr_* outputs.
// A combinational query port lets decode detect and forward pending writes.
//
// Ports
//   clock, reset_n           rising-edge clock, async active-low reset
//   in_valid / in_ready      result handshake (in_ready from pre-edge count)
//   in_opcode/in_rd/in_result  retiring instruction opcode, dest, value
//   wr_stall                 register file cannot take a write this cycle
//   wr_enable/wr_addr/wr_data  registered register-file write port
//   query_addr               register decode is about to read
//   query_hit/query_data     youngest pending value for query_addr
//   count                    entries currently queued
//   err_addr                 one-cycle pulse when an illegal rd is dropped
// -----------------------------------------------------------------------------
module wb_write_queue #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 7,
  parameter int NUM_REGS = 32,
  parameter int DEPTH    = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_opcode,
  input  logic [ADDR_W-1:0]          in_rd,
  input  logic [DATA_W-1:0]          in_result,
  input  logic                       wr_stall,
  output logic                       wr_enable,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  input  logic [ADDR_W-1:0]          query_addr,
  output logic                       query_hit,
  output logic [DATA_W-1:0]          query_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Opcodes that write a destination register: 1 (Lv), 2-5, 6 (Cp), 9 (slr).
  function automatic logic is_write_op(input logic [4:0] op);
    logic wr;
    case (op)
      5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd9: wr = 1'b1;
      default:                                  wr = 1'b0;
    endcase
    return wr;
  endfunction

  logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_enable_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              err_addr_q;

  logic              ready_s;
  logic              accept_s;
  logic              rd_legal_s;
  logic              push_s;
  logic              pop_s;
  logic              err_s;
  logic              query_hit_s;
  logic [DATA_W-1:0] query_data_s;
  logic [PTR_W-1:0]  idx_s;

  // Handshake decode, push/pop qualification and next-state pointers/count.
  always_comb begin
    ready_s    = (count_q != CNT_W'(DEPTH));
    accept_s   = in_valid & ready_s;
    // Compare at 32 bits so NUM_REGS need not fit in ADDR_W.
    rd_legal_s = ({{(32-ADDR_W){1'b0}}, in_rd} < 32'(NUM_REGS));
    push_s     = accept_s & is_write_op(in_opcode) & rd_legal_s;
    err_s      = accept_s & is_write_op(in_opcode) & ~rd_legal_s;
    pop_s      = (count_q != {CNT_W{1'b0}}) & ~wr_stall;
    // Pointers are PTR_W wide, so +1 wraps modulo DEPTH (power of two).
    head_d     = pop_s  ? head_q + {{(PTR_W-1){1'b0}}, 1'b1} : head_q;
    tail_d     = push_s ? tail_q + {{(PTR_W-1){1'b0}}, 1'b1} : tail_q;
    count_d    = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  // Queue pointers, occupancy and error pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= {PTR_W{1'b0}};
      tail_q     <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      err_addr_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      err_addr_q <= err_s;
    end
  end

  // Queue storage: the tail slot captures the accepted entry on a push.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= {ADDR_W{1'b0}};
        data_mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      rd_mem_q[tail_q]   <= in_rd;
      data_mem_q[tail_q] <= in_result;
    end else begin
      rd_mem_q[tail_q]   <= rd_mem_q[tail_q];
      data_mem_q[tail_q] <= data_mem_q[tail_q];
    end
  end

  // Register-file write port: head moves out on a pop; address/data hold otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_enable_q <= 1'b0;
      wr_addr_q   <= {ADDR_W{1'b0}};
      wr_data_q   <= {DATA_W{1'b0}};
    end else if (pop_s) begin
      wr_enable_q <= 1'b1;
      wr_addr_q   <= rd_mem_q[head_q];
      wr_data_q   <= data_mem_q[head_q];
    end else begin
      wr_enable_q <= 1'b0;
    end
  end

  // Pending-write search: the outgoing write is checked first, then queue
  // entries oldest to youngest, so later matches override earlier ones.
  always_comb begin
    query_hit_s  = 1'b0;
    query_data_s = {DATA_W{1'b0}};
    idx_s        = head_q;
    if (wr_enable_q && (wr_addr_q == query_addr)) begin
      query_hit_s  = 1'b1;
      query_data_s = wr_data_q;
    end else begin
      query_hit_s  = 1'b0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (rd_mem_q[idx_s] == query_addr)) begin
        query_hit_s  = 1'b1;
        query_data_s = data_mem_q[idx_s];
      end else begin
        query_hit_s  = query_hit_s;
      end
    end
  end

  assign in_ready   = ready_s;
  assign wr_enable  = wr_enable_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign query_hit  = query_hit_s;
  assign query_data = query_data_s;
  assign count      = count_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_wb_write_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_write_queue: directed testbench for wb_write_queue. Inputs are driven
// 1 time unit after each rising edge and outputs are sampled 1 more unit later.
// -----------------------------------------------------------------------------
module tb_wb_write_queue;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [6:0]  in_rd;
  logic [31:0] in_result;
  logic        wr_stall;
  logic        wr_enable;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic [6:0]  query_addr;
  logic        query_hit;
  logic [31:0] query_data;
  logic [2:0]  count;
  logic        err_addr;

  int checks = 0;
  int errors = 0;

  wb_write_queue #(.DATA_W(32), .ADDR_W(7), .NUM_REGS(32), .DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_result(in_result), .wr_stall(wr_stall),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .query_addr(query_addr), .query_hit(query_hit), .query_data(query_data),
    .count(count), .err_addr(err_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_opcode = 5'd0;
    in_rd     = 7'd0;
    in_result = 32'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_stall = 1'b0; query_addr = 7'd0;
    idle_inputs();
    #12;
    checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL rst_wr_enable got %0b exp 0", wr_enable); end
    checks++; if (wr_addr !== 7'd0) begin errors++; $display("FAIL rst_wr_addr got %0d exp 0", wr_addr); end
    checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL rst_wr_data got %h exp 0", wr_data); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    checks++; if (err_addr !== 1'b0) begin errors++; $display("FAIL rst_err_addr got %0b exp 0", err_addr); end
    @(negedge clock);
    reset_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
  endtask

  // Single write, rd=5: edge 1 accepts, write visible only between edges 2 and 3.
  task automatic test_single_write();
    query_addr = 7'd5;
    in_valid = 1'b1; in_opcode = 5'd2; in_rd = 7'd5; in_result = 32'h0000_1234;
    step(); // edge 1
    idle_inputs(); #1;
    checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL sw_e1_wr_enable got %0b exp 0", wr_enable); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL sw_e1_count got %0d exp 1", count); end
    checks++; if (query_hit !== 1'b1 || query_data !== 32'h1234) begin errors++; $display("FAIL sw_e1_query got %0b/%h exp 1/1234", query_hit, query_data); end
    step(); // edge 2
    checks++; if (wr_enable !== 1'b1 || wr_addr !== 7'd5 || wr_data !== 32'h1234) begin errors++; $display("FAIL sw_e2_write got %0b/%0d/%h exp 1/5/1234", wr_enable, wr_addr, wr_data); end
    checks++; if (query_hit !== 1'b1 || query_data !== 32'h1234) begin errors++; $display("FAIL sw_e2_query got %0b/%h exp 1/1234", query_hit, query_data); end
    step(); // edge 3
    checks++; if (wr_enable !== 1'b0 || wr_addr !== 7'd5) begin errors++; $display("FAIL sw_e3_write got %0b/%0d exp 0/5", wr_enable, wr_addr); end
    checks++; if (query_hit !== 1'b0 || query_data !== 32'd0) begin errors++; $display("FAIL sw_e3_query got %0b/%h exp 0/0", query_hit, query_data); end
  endtask

  task automatic test_nonwriting();
    in_valid = 1'b1; in_opcode = 5'd7; in_rd = 7'd3; in_result = 32'h77;
    step();
    checks++; if (count !== 3'd0 || err_addr !== 1'b0) begin errors++; $display("FAIL nw_op7 count/err got %0d/%0b exp 0/0", count, err_addr); end
    in_opcode = 5'd8; in_rd = 7'd40;
    step();
    checks++; if (count !== 3'd0 || err_addr !== 1'b0 || wr_enable !== 1'b0) begin errors++; $display("FAIL nw_op8 count/err/we got %0d/%0b/%0b exp 0/0/0", count, err_addr, wr_enable); end
    idle_inputs();
    step();
    checks++; if (wr_enable !== 1'b0 || err_addr !== 1'b0) begin errors++; $display("FAIL nw_after we/err got %0b/%0b exp 0/0", wr_enable, err_addr); end
  endtask

  // Fill under stall, hold rd=5 on the input, then drain in order.
  task automatic test_full_stall();
    wr_stall = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      in_valid = 1'b1; in_opcode = 5'd1; in_rd = 7'(r); in_result = 32'h100 + 32'(r);
      step();
    end
    in_rd = 7'd5; in_result = 32'h105; #1;
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL full count/ready got %0d/%0b exp 4/0", count, in_ready); end
    step();
    checks++; if (count !== 3'd4 || wr_enable !== 1'b0) begin errors++; $display("FAIL full_hold count/we got %0d/%0b exp 4/0", count, wr_enable); end
    wr_stall = 1'b0;
    step(); // pop rd1; rd5 not accepted (pre-edge full)
    checks++; if (wr_enable !== 1'b1 || wr_addr !== 7'd1 || wr_data !== 32'h101 || count !== 3'd3) begin errors++; $display("FAIL drain1 got %0b/%0d/%h/%0d exp 1/1/101/3", wr_enable, wr_addr, wr_data, count); end
    step(); // pop rd2, push rd5
    idle_inputs();
    checks++; if (wr_enable !== 1'b1 || wr_addr !== 7'd2 || wr_data !== 32'h102 || count !== 3'd3) begin errors++; $display("FAIL drain2 got %0b/%0d/%h/%0d exp 1/2/102/3", wr_enable, wr_addr, wr_data, count); end
    for (int r = 3; r <= 5; r++) begin
      step();
      checks++; if (wr_enable !== 1'b1 || wr_addr !== 7'(r) || wr_data !== (32'h100 + 32'(r))) begin errors++; $display("FAIL drain%0d got %0b/%0d/%h exp 1/%0d", r, wr_enable, wr_addr, wr_data, r); end
    end
    step();
    checks++; if (wr_enable !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL drain_end we/count got %0b/%0d exp 0/0", wr_enable, count); end
  endtask

  task automatic test_query_priority();
    wr_stall = 1'b1; query_addr = 7'd3;
    in_valid = 1'b1; in_opcode = 5'd3; in_rd = 7'd3; in_result = 32'hA;
    step();
    in_result = 32'hB;
    step();
    idle_inputs(); #1;
    checks++; if (query_hit !== 1'b1 || query_data !== 32'hB) begin errors++; $display("FAIL qp_queued got %0b/%h exp 1/b", query_hit, query_data); end
    wr_stall = 1'b0;
    step(); // 0xA retires; 0xB still queued
    wr_stall = 1'b1; #1;
    checks++; if (wr_enable !== 1'b1 || wr_data !== 32'hA) begin errors++; $display("FAIL qp_pop got %0b/%h exp 1/a", wr_enable, wr_data); end
    checks++; if (query_hit !== 1'b1 || query_data !== 32'hB) begin errors++; $display("FAIL qp_after_pop got %0b/%h exp 1/b", query_hit, query_data); end
    query_addr = 7'd4; #1;
    checks++; if (query_hit !== 1'b0 || query_data !== 32'd0) begin errors++; $display("FAIL qp_miss got %0b/%h exp 0/0", query_hit, query_data); end
    wr_stall = 1'b0;
    step();
    step();
    checks++; if (count !== 3'd0 || wr_enable !== 1'b0) begin errors++; $display("FAIL qp_drain count/we got %0d/%0b exp 0/0", count, wr_enable); end
  endtask

  task automatic test_illegal_rd();
    in_valid = 1'b1; in_opcode = 5'd2; in_rd = 7'd40; in_result = 32'hDEAD;
    step();
    idle_inputs(); #1;
    checks++; if (err_addr !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL ill_pulse err/count got %0b/%0d exp 1/0", err_addr, count); end
    step();
    checks++; if (err_addr !== 1'b0 || wr_enable !== 1'b0) begin errors++; $display("FAIL ill_after err/we got %0b/%0b exp 0/0", err_addr, wr_enable); end
    step();
    checks++; if (wr_enable !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL ill_nowrite we/count got %0b/%0d exp 0/0", wr_enable, count); end
  endtask

  // Reset while a write is on the port and entries are queued.
  task automatic test_reset_midstream();
    wr_stall = 1'b1;
    for (int r = 10; r <= 12; r++) begin
      in_valid = 1'b1; in_opcode = 5'd6; in_rd = 7'(r); in_result = 32'(r);
      step();
    end
    idle_inputs();
    wr_stall = 1'b0;
    step();
    checks++; if (wr_enable !== 1'b1 || wr_addr !== 7'd10) begin errors++; $display("FAIL mr_pre we/addr got %0b/%0d exp 1/10", wr_enable, wr_addr); end
    reset_n = 1'b0; #1;
    checks++; if (wr_enable !== 1'b0 || count !== 3'd0 || err_addr !== 1'b0) begin errors++; $display("FAIL mr_in_reset we/count/err got %0b/%0d/%0b exp 0/0/0", wr_enable, count, err_addr); end
    @(negedge clock);
    reset_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_ready got %0b exp 1", in_ready); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (wr_enable !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL mr_quiet%0d we/count got %0b/%0d exp 0/0", c, wr_enable, count); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_nonwriting();
    test_full_stall();
    test_query_priority();
    test_illegal_rd();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
